// File: rtl/fn_rec_pkg.sv
// Shared widths, FSM states and exponent constants for the IEEE-to-recoded float converter.
// The converter is single-operand and valid/ready handshaked; nothing in this package holds state.
package fn_rec_pkg;
  localparam int EXP_W     = 11;
  localparam int SIG_W     = 53;
  localparam int FRAC_W    = SIG_W - 1;
  localparam int REC_EXP_W = EXP_W + 1;
  localparam int CNT_W     = 6;

  localparam logic [REC_EXP_W-1:0] BIAS_NORM = 12'h401;
  localparam logic [REC_EXP_W-1:0] BIAS_SUB  = 12'h402;
  localparam logic [REC_EXP_W-1:0] EXP_ZERO  = 12'h000;
  localparam logic [REC_EXP_W-1:0] EXP_INF   = 12'hC00;
  localparam logic [REC_EXP_W-1:0] EXP_NAN   = 12'hE00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fn_classify.sv
// Combinational operand classification: zero, subnormal, infinity, NaN (plus signalling NaN
// when FN_TO_REC_FN_SNAN_FLAG_EN is defined). Zero latency, no flow control.
module fn_classify #(
  parameter int EXP_WIDTH = 11,
  parameter int SIG_WIDTH = 53
) (
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [SIG_WIDTH-2:0] frac_in,
  output logic                 is_zero,
  output logic                 is_sub,
  output logic                 is_inf,
`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
  output logic                 is_snan,
`endif
  output logic                 is_nan
);
  logic exp_zero, exp_ones, frac_zero;

  assign exp_zero  = (exp_in == '0);
  assign exp_ones  = &exp_in;
  assign frac_zero = (frac_in == '0);

  assign is_zero = exp_zero & frac_zero;
  assign is_sub  = exp_zero & ~frac_zero;
  assign is_inf  = exp_ones & frac_zero;
  assign is_nan  = exp_ones & ~frac_zero;
`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
  // Quiet bit clear marks a signalling NaN.
  assign is_snan = is_nan & ~frac_in[SIG_WIDTH-2];
`endif
endmodule

// File: rtl/fn_to_rec_fn_iter.sv
// IEEE binary64 to recoded-float converter; normals/specials 1 cycle, subnormals k+2 cycles (k = leading zeros),
// result held until io_out_ready; FN_TO_REC_FN_SNAN_FLAG_EN adds a registered io_out_snan flag.
module fn_to_rec_fn_iter
  import fn_rec_pkg::*;
#(
  parameter int EXP_WIDTH = EXP_W,
  parameter int SIG_WIDTH = SIG_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           io_in_valid,
  output logic                           io_in_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH-1:0] io_in_bits,
  output logic                           io_out_valid,
  input  logic                           io_out_ready,
`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
  output logic                           io_out_snan,
`endif
  output logic [EXP_WIDTH+SIG_WIDTH:0]   io_out_bits
);
  localparam int FW = SIG_WIDTH - 1;
  localparam int RW = EXP_WIDTH + 1;
  localparam int IW = EXP_WIDTH + SIG_WIDTH;

  state_t            state_q, state_d;
  logic [FW-1:0]     shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sign_q;
  logic [IW:0]       out_q;

  logic                 in_sign;
  logic [EXP_WIDTH-1:0] in_exp;
  logic [FW-1:0]        in_frac;
  logic                 is_zero, is_sub, is_inf, is_nan;
  logic                 accept, load_direct, load_sub, start_norm;
  logic [RW-1:0]        direct_exp, sub_exp;
  logic [FW-1:0]        shifted;
  logic                 msb;

  assign in_sign = io_in_bits[IW-1];
  assign in_exp  = io_in_bits[IW-2 -: EXP_WIDTH];
  assign in_frac = io_in_bits[FW-1:0];

`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
  logic is_snan;
  logic snan_q;
`endif

  fn_classify #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH)) u_classify (
    .exp_in  (in_exp),
    .frac_in (in_frac),
    .is_zero (is_zero),
    .is_sub  (is_sub),
    .is_inf  (is_inf),
`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
    .is_snan (is_snan),
`endif
    .is_nan  (is_nan)
  );

  assign io_in_ready  = (state_q == IDLE) | ((state_q == DONE) & io_out_ready);
  assign io_out_valid = (state_q == DONE);
  assign io_out_bits  = out_q;
  assign accept       = io_in_valid & io_in_ready;

  assign msb     = shreg_q[FW-1];
  assign shifted = {shreg_q[FW-2:0], 1'b0};
  // Subnormal exponent is ~k + 0x402 in RW bits; the upper bits of ~k are all ones.
  assign sub_exp = {{(RW-CNT_W){1'b1}}, ~cnt_q} + BIAS_SUB;

  always_comb begin
    direct_exp = {1'b0, in_exp} + BIAS_NORM;
    if (is_zero)     direct_exp = EXP_ZERO;
    else if (is_inf) direct_exp = EXP_INF;
    else if (is_nan) direct_exp = EXP_NAN;
  end

  always_comb begin
    state_d     = state_q;
    load_direct = 1'b0;
    load_sub    = 1'b0;
    start_norm  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_sub) begin
            state_d    = NORM;
            start_norm = 1'b1;
          end else begin
            state_d     = DONE;
            load_direct = 1'b1;
          end
        end else if (state_q == DONE && io_out_ready) begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (msb) begin
          state_d  = DONE;
          load_sub = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      if (start_norm) begin
        shreg_q <= in_frac;
        cnt_q   <= '0;
        sign_q  <= in_sign;
      end else if (state_q == NORM) begin
        shreg_q <= shifted;
        if (!msb) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (load_direct) out_q <= {in_sign, direct_exp, in_frac};
      else if (load_sub) out_q <= {sign_q, sub_exp, shifted};
    end
  end

`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)            snan_q <= 1'b0;
    else if (load_direct) snan_q <= is_snan;
    else if (load_sub)    snan_q <= 1'b0;
  end
  assign io_out_snan = snan_q;
`endif
endmodule

// File: tb/tb_fn_to_rec_fn_iter.sv
// Directed bench for fn_to_rec_fn_iter: hand-computed recodings, latencies, backpressure and mid-flight reset.
module tb_fn_to_rec_fn_iter;
  logic        clk = 1'b0;
  logic        reset;
  logic        io_in_valid, io_in_ready, io_out_valid, io_out_ready;
  logic [63:0] io_in_bits;
  logic [64:0] io_out_bits;
`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
  logic        io_out_snan;
`endif

  always #5 clk = ~clk;

  fn_to_rec_fn_iter dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
    .io_out_snan  (io_out_snan),
`endif
    .io_out_bits  (io_out_bits)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand, then count cycles until io_out_valid (result left pending, out_ready low).
  task automatic issue(input logic [63:0] v, output int lat, output logic rdy_low);
    io_in_bits  = v;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    io_in_bits  = ~v;
    lat     = 1;
    rdy_low = 1'b1;
    while (!io_out_valid && lat < 100) begin
      if (io_in_ready) rdy_low = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] in;
    logic [64:0] out;
    int          lat;
    logic        snan;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat;
    logic        rdy_low;
    logic [64:0] held;

    vecs[0] = '{64'h3FF0000000000000, 65'h0_8000_0000_0000_0000, 1,  1'b0};
    vecs[1] = '{64'h8000000000000000, 65'h1_0000_0000_0000_0000, 1,  1'b0};
    vecs[2] = '{64'h7FF0000000000000, 65'h0_C000_0000_0000_0000, 1,  1'b0};
    vecs[3] = '{64'h0000000000000001, 65'h0_3CE0_0000_0000_0000, 53, 1'b0};
    vecs[4] = '{64'h7FF0000000000001, 65'h0_E000_0000_0000_0001, 1,  1'b1};
    vecs[5] = '{64'h7FF8000000000000, 65'h0_E008_0000_0000_0000, 1,  1'b0};
    vecs[6] = '{64'h0008000000000000, 65'h0_4010_0000_0000_0000, 2,  1'b0};
    vecs[7] = '{64'h8004000000000001, 65'h1_4000_0000_0000_0004, 3,  1'b0};
    vecs[8] = '{64'h7FEFFFFFFFFFFFFF, 65'h0_BFFF_FFFF_FFFF_FFFF, 1,  1'b0};
    vecs[9] = '{64'h0010000000000000, 65'h0_4020_0000_0000_0000, 1,  1'b0};

    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
    io_in_bits   = '0;
    tick();
    tick();
    chk("rst_out_valid", 65'(io_out_valid), 65'd0);
    chk("rst_out_bits", io_out_bits, 65'd0);
`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
    chk("rst_snan", 65'(io_out_snan), 65'd0);
`endif
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 65'(io_in_ready), 65'd1);

    foreach (vecs[i]) begin
      chk($sformatf("v%0d_in_ready", i), 65'(io_in_ready), 65'd1);
      issue(vecs[i].in, lat, rdy_low);
      chk($sformatf("v%0d_bits", i), io_out_bits, vecs[i].out);
      chk($sformatf("v%0d_lat", i), 65'(lat), 65'(vecs[i].lat));
      chk($sformatf("v%0d_rdy_low", i), 65'(rdy_low), 65'd1);
`ifdef FN_TO_REC_FN_SNAN_FLAG_EN
      chk($sformatf("v%0d_snan", i), 65'(io_out_snan), 65'(vecs[i].snan));
`endif
      retire();
      chk($sformatf("v%0d_retired", i), 65'(io_out_valid), 65'd0);
    end

    // Backpressure then back-to-back retire+accept.
    issue(64'h3FF0000000000000, lat, rdy_low);
    held = io_out_bits;
    chk("bp_first", held, 65'h0_8000_0000_0000_0000);
    for (int c = 0; c < 5; c++) begin
      io_in_valid = 1'b1;
      io_in_bits  = 64'h4000000000000000 + 64'(c);
      #1;
      chk($sformatf("bp_stable%0d", c), io_out_bits, 65'h0_8000_0000_0000_0000);
      chk($sformatf("bp_in_ready%0d", c), 65'(io_in_ready), 65'd0);
      chk($sformatf("bp_valid%0d", c), 65'(io_out_valid), 65'd1);
      io_in_valid = 1'b0;
      tick();
    end
    io_out_ready = 1'b1;
    io_in_valid  = 1'b1;
    io_in_bits   = 64'hC000000000000000;
    #1;
    chk("b2b_in_ready", 65'(io_in_ready), 65'd1);
    tick();
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
    io_in_bits   = '0;
    chk("b2b_valid", 65'(io_out_valid), 65'd1);
    chk("b2b_bits", io_out_bits, 65'h1_8010_0000_0000_0000);
    retire();

    // Reset during the 10th NORM cycle of the slowest subnormal.
    io_in_bits  = 64'h0000000000000001;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 65'(io_out_valid), 65'd0);
    chk("mid_rst_bits", io_out_bits, 65'd0);
    chk("mid_rst_idle", 65'(io_in_ready), 65'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready_after", 65'(io_in_ready), 65'd1);
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 70; c++) begin
        if (io_out_valid) seen = 1'b1;
        tick();
      end
      chk("mid_rst_no_stale", 65'(seen), 65'd0);
    end
    chk("mid_rst_bits_late", io_out_bits, 65'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fn_to_rec_fn_iter.md
FN_TO_REC_FN_ITER -- requirements
Module: fn_to_rec_fn_iter

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 11, exponent width of the IEEE input.
REQ-002 SHALL have parameter SIG_WIDTH, default 53, significand width including the hidden bit; recoded width is EXP_WIDTH+SIG_WIDTH+1.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port io_in_valid  input  1  IEEE operand valid.
REQ-006 SHALL have port io_in_ready  output  1  block accepts the operand this cycle.
REQ-007 SHALL have port io_in_bits  input  64  IEEE binary64 value: sign [63], exponent [62:52], fraction [51:0].
REQ-008 SHALL have port io_out_valid  output  1  recoded result valid.
REQ-009 SHALL have port io_out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port io_out_bits  output  65  recoded value: sign [64], exponent [63:52], fraction [51:0].

Function
REQ-011 SHALL use an FSM with states IDLE, NORM, DONE; io_in_ready = IDLE | (DONE & io_out_ready); io_out_valid = DONE.
REQ-012 SHALL transfer on valid&ready at each port; io_out_bits SHALL stay stable while DONE & !io_out_ready.
REQ-013 Accept with input exponent != 0, or with exponent == 0 and fraction == 0: SHALL go to DONE next cycle, so result is valid 1 cycle after acceptance.
REQ-014 Accept with exponent == 0 and fraction != 0 (subnormal): SHALL go to NORM, load the fraction into a shift register and clear the 6-bit distance counter.
REQ-015 In NORM, each cycle: if shreg[51] == 0, shift left 1 and increment counter; else shift left 1, dropping the leading one, and go to DONE. Result valid k+2 cycles after acceptance, where k = leading zeros of the fraction (0..51).
REQ-016 Adjusted exponent, 12 bits modulo 2^12: normal = exp + 0x401; subnormal = (~k & 0xFFF) + 0x402; zero = 0.
REQ-017 Output exponent for normal/subnormal SHALL be the adjusted exponent. Zero: 0x000. Exponent 0x7FF with fraction == 0 (Inf): 0xC00. Exponent 0x7FF with fraction != 0 (NaN): 0xE00.
REQ-018 Output fraction SHALL be the input fraction, except for subnormals, where it is the normalized shreg; NaN payload SHALL pass through unchanged. Output sign SHALL be the input sign.
REQ-019 An accept in DONE with io_out_ready high SHALL return the current result and begin the new operand in the same cycle, with no bubble.
REQ-020 io_in_bits SHALL be sampled only on acceptance; changes afterwards SHALL have no effect.

Reset
REQ-021 reset SHALL force IDLE, io_out_valid=0, io_out_bits=0, counter=0 and shreg=0 on the next edge, including during NORM or DONE; any in-flight operand SHALL be discarded.
REQ-022 io_in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-023 With FN_TO_REC_FN_SNAN_FLAG_EN defined, the block SHALL add port io_out_snan (output, 1 bit), registered with io_out_bits and reset to 0. It SHALL be 1 when the input has exponent 0x7FF, fraction != 0 and fraction[51] == 0.
REQ-024 Without FN_TO_REC_FN_SNAN_FLAG_EN, the io_out_snan port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 A shared package fn_rec_pkg SHALL hold the FSM state enum, the widths, the bias constants 0x401/0x402, and the special exponent codes 0x000/0xC00/0xE00.
REQ-026 Classification (zero/subnormal/Inf/NaN/sNaN) SHALL live in one combinational sub-module, fn_classify.

Verification
REQ-027 in 0x3FF0000000000000 (1.0) -> out 0x0_8000_0000_0000_0000, valid 1 cycle after accept.
REQ-028 in 0x8000000000000000 (-0) -> out 0x1_0000_0000_0000_0000, latency 1; 0x7FF0000000000000 (+Inf) -> out 0x0_C000_0000_0000_0000.
REQ-029 in 0x0000000000000001 (min subnormal, k=51) -> out 0x0_3CE0_0000_0000_0000, valid exactly 53 cycles after accept, io_in_ready low throughout.
REQ-030 in 0x7FF0000000000001 -> out 0x0_E000_0000_0000_0001 with io_out_snan=1; in 0x7FF8000000000000 -> io_out_snan=0 (macro defined build).
REQ-031 Hold io_out_ready low 5 cycles in DONE -> io_out_bits stable, io_in_ready low. Then raise io_out_ready together with io_in_valid -> result retired and new operand accepted in the same cycle.
REQ-032 Assert reset at the 10th NORM cycle of a subnormal -> next cycle IDLE, io_out_valid=0, io_out_bits=0, and no stale result is ever emitted.
